// File: rtl/err_pkg.sv
// Shared types and defaults for the bit-error checker.
// Imported by the FIFO and the top level.
package err_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 24;
  localparam int WIN_W_DEF = 16;

endpackage

// File: rtl/bit_fifo.sv
// 1-bit synchronous FIFO, show-ahead head output.
// A push while full is accepted only together with a pop.
module bit_fifo
  import err_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, rd_q;
  logic        mem_q [DEPTH];
  logic        do_pop, do_push;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  // Pointer update; extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/err_checker.sv
// Bit-error counter: buffers reference bits, compares
// decoded bits against them over a programmable window.
module err_checker
  import err_pkg::*;
#(
  parameter int FIFO_DEPTH = 1024,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN_W      = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [WIN_W-1:0] i_window,
  input  logic             i_ref_vld,
  input  logic             i_ref_bit,
  input  logic             i_dec_vld,
  input  logic             i_dec_bit,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic             o_ovf,
  output logic             o_unf
);

  state_e           state_q;
  logic             busy_q, done_q;
  logic             ovf_q, unf_q;
  logic [CNT_W-1:0] err_q, bit_q;
  logic [WIN_W-1:0] left_q;
  logic             full, empty, head;
  logic             pop, mism;

  bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (i_ref_vld),
    .pop_i   (i_dec_vld),
    .din_i   (i_ref_bit),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign pop  = i_dec_vld && !empty;
  assign mism = pop && (i_dec_bit ^ head);

  // Sticky FIFO health flags; a full push paired
  // with a pop is not an overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (i_ref_vld && full && !pop) ovf_q <= 1'b1;
      if (i_dec_vld && empty)        unf_q <= 1'b1;
    end
  end

  // Window FSM and counters. The window ends on a
  // down-counter of remaining pops, so termination
  // stays exact even if the counts are narrower
  // than the window and saturate.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      bit_q   <= '0;
      left_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (i_start) begin
        err_q  <= '0;
        bit_q  <= '0;
        left_q <= i_window;
        if (i_window != '0) begin
          state_q <= MEASURE;
          busy_q  <= 1'b1;
        end else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end else begin
        unique case (state_q)
          IDLE: ;
          MEASURE: begin
            if (pop) begin
              if (!(&bit_q))
                bit_q <= bit_q + CNT_W'(1);
              if (mism && !(&err_q))
                err_q <= err_q + CNT_W'(1);
              left_q <= left_q - WIN_W'(1);
              if (left_q == WIN_W'(1)) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          DONE: state_q <= IDLE;
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err_cnt = err_q;
  assign o_bit_cnt = bit_q;
  assign o_ovf     = ovf_q;
  assign o_unf     = unf_q;

endmodule

// File: tb/tb_err_checker.sv
// Bench for err_checker: two instances (large FIFO,
// and small FIFO with narrow counts) against a queue model.
module tb_err_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] win;
  logic        rv, rb, dv, db;

  logic        busy0, done0, ovf0, unf0;
  logic [23:0] err0, bit0;
  logic        busy1, done1, ovf1, unf1;
  logic [3:0]  err1, bit1;

  always #5 clk = ~clk;

  err_checker #(.FIFO_DEPTH(1024), .CNT_W(24),
                .WIN_W(16)) u_big (
    .clk(clk), .reset_n(reset_n),
    .i_start(start), .i_window(win),
    .i_ref_vld(rv), .i_ref_bit(rb),
    .i_dec_vld(dv), .i_dec_bit(db),
    .o_busy(busy0), .o_done(done0),
    .o_err_cnt(err0), .o_bit_cnt(bit0),
    .o_ovf(ovf0), .o_unf(unf0)
  );

  err_checker #(.FIFO_DEPTH(8), .CNT_W(4),
                .WIN_W(16)) u_small (
    .clk(clk), .reset_n(reset_n),
    .i_start(start), .i_window(win),
    .i_ref_vld(rv), .i_ref_bit(rb),
    .i_dec_vld(dv), .i_dec_bit(db),
    .o_busy(busy1), .o_done(done1),
    .o_err_cnt(err1), .o_bit_cnt(bit1),
    .o_ovf(ovf1), .o_unf(unf1)
  );

  int ncmp = 0;
  int nerr = 0;
  int dcnt [2];

  function automatic void chk(string nm, int act,
                              int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d",
               nm, act, exp);
    end
  endfunction

  // Behavioural model: a plain queue of pending
  // reference bits plus window bookkeeping in ints.
  bit q0[$];
  bit q1[$];
  int depth [2] = '{1024, 8};
  int cmax  [2] = '{16777215, 15};
  int m_bits [2], m_errs [2], m_tgt [2];
  bit m_meas [2], m_done [2];
  bit m_ovf [2], m_unf [2];

  function automatic int qsize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic bit qhead(int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void qpop(int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void qpush(int i, bit b);
    if (i == 0) q0.push_back(b);
    else        q1.push_back(b);
  endfunction

  function automatic int sat(int i, int v);
    return (v > cmax[i]) ? cmax[i] : v;
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        if (i == 0) q0.delete(); else q1.delete();
        m_bits[i] = 0; m_errs[i] = 0; m_tgt[i] = 0;
        m_meas[i] = 0; m_done[i] = 0;
        m_ovf[i] = 0;  m_unf[i] = 0;
      end else begin
        int  sz;
        bit  popok, pushok, mis;
        sz     = qsize(i);
        popok  = dv && sz > 0;
        pushok = rv && (sz < depth[i] || popok);
        mis    = popok && (db != qhead(i));
        if (rv && !pushok) m_ovf[i] = 1;
        if (dv && sz == 0) m_unf[i] = 1;
        if (popok) qpop(i);
        if (pushok) qpush(i, rb);
        m_done[i] = 0;
        if (start) begin
          m_bits[i] = 0;
          m_errs[i] = 0;
          m_tgt[i]  = int'(win);
          m_meas[i] = (win != 0);
        end else if (m_meas[i] && popok) begin
          m_bits[i]++;
          m_errs[i] += int'(mis);
          if (m_bits[i] == m_tgt[i]) begin
            m_meas[i] = 0;
            m_done[i] = 1;
          end
        end
      end
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    dcnt[0] += int'(done0);
    dcnt[1] += int'(done1);
    chk("busy0", int'(busy0), int'(m_meas[0]));
    chk("done0", int'(done0), int'(m_done[0]));
    chk("err0", int'(err0), sat(0, m_errs[0]));
    chk("bit0", int'(bit0), sat(0, m_bits[0]));
    chk("ovf0", int'(ovf0), int'(m_ovf[0]));
    chk("unf0", int'(unf0), int'(m_unf[0]));
    chk("busy1", int'(busy1), int'(m_meas[1]));
    chk("done1", int'(done1), int'(m_done[1]));
    chk("err1", int'(err1), sat(1, m_errs[1]));
    chk("bit1", int'(bit1), sat(1, m_bits[1]));
    chk("ovf1", int'(ovf1), int'(m_ovf[1]));
    chk("unf1", int'(unf1), int'(m_unf[1]));
  endtask

  task automatic drive(bit s, int w, bit a, bit b,
                       bit c, bit d);
    start = s; win = 16'(w);
    rv = a; rb = b; dv = c; db = d;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    cyc();
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_bit", int'(bit0), 0);
    reset_n = 1'b1;
    dcnt[0] = 0;
    dcnt[1] = 0;
  endtask

  // Ref stream pushed at t, decoded copy at t+dly.
  // Bit k of the decoded stream inverted if flip[k].
  task automatic stream(int n, int dly, int w,
                        int rs_at, int rs_w,
                        bit flip [200]);
    bit r [200];
    for (int k = 0; k < n; k++) r[k] = 1'($urandom);
    for (int t = 0; t < n + dly + 4; t++) begin
      bit a, b, c, d, s;
      int ww, k;
      k  = t - dly;
      a  = (t < n);
      b  = a ? r[t] : 1'b0;
      c  = (k >= 0 && k < n);
      d  = c ? (r[k] ^ flip[k]) : 1'b0;
      s  = (t == 0) || (c && k == rs_at);
      ww = (t == 0) ? w : rs_w;
      drive(s, ww, a, b, c, d);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit s; int w; bit a, b, c, d;
    bit ebusy, edone;
    int eerr, ebit;
    bit eovf, eunf;
  } vec_t;

  vec_t tbl [7];
  bit   nofl [200];
  bit   fl [200];

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    dcnt[0] = 0;
    dcnt[1] = 0;
    for (int k = 0; k < 200; k++) nofl[k] = 0;

    // Directed table on the large instance.
    tbl[0] = '{1, 2, 0,0,0,0, 1,0, 0,0, 0,0};
    tbl[1] = '{0, 0, 1,1,0,0, 1,0, 0,0, 0,0};
    tbl[2] = '{0, 0, 1,0,1,0, 1,0, 1,1, 0,0};
    tbl[3] = '{0, 0, 0,0,1,0, 0,1, 1,2, 0,0};
    tbl[4] = '{0, 0, 0,0,0,0, 0,0, 1,2, 0,0};
    tbl[5] = '{0, 0, 0,0,1,0, 0,0, 1,2, 0,1};
    tbl[6] = '{1, 0, 0,0,0,0, 0,0, 0,0, 0,1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].s, tbl[i].w, tbl[i].a,
            tbl[i].b, tbl[i].c, tbl[i].d);
      cyc();
      chk($sformatf("tbl%0d_busy", i),
          int'(busy0), int'(tbl[i].ebusy));
      chk($sformatf("tbl%0d_done", i),
          int'(done0), int'(tbl[i].edone));
      chk($sformatf("tbl%0d_err", i),
          int'(err0), tbl[i].eerr);
      chk($sformatf("tbl%0d_bit", i),
          int'(bit0), tbl[i].ebit);
      chk($sformatf("tbl%0d_ovf", i),
          int'(ovf0), int'(tbl[i].eovf));
      chk($sformatf("tbl%0d_unf", i),
          int'(unf0), int'(tbl[i].eunf));
    end

    // Error-free, decoded delayed 37 cycles.
    do_reset();
    stream(100, 37, 100, -1, 0, nofl);
    chk("clean_done", dcnt[0], 1);
    chk("clean_err", int'(err0), 0);
    chk("clean_bit", int'(bit0), 100);
    chk("clean_ovf", int'(ovf0), 0);
    chk("clean_unf", int'(unf0), 0);

    // Decoded bits 10, 20, 30 inverted.
    for (int k = 0; k < 200; k++) fl[k] = 0;
    fl[10] = 1; fl[20] = 1; fl[30] = 1;
    do_reset();
    stream(70, 5, 64, -1, 0, fl);
    chk("inj_done", dcnt[0], 1);
    chk("inj_err", int'(err0), 3);
    chk("inj_bit", int'(bit0), 64);

    // Restart at pop 50 with a 10-bit window.
    do_reset();
    stream(80, 3, 100, 50, 10, nofl);
    chk("rs_done", dcnt[0], 1);
    chk("rs_bit", int'(bit0), 10);
    chk("rs_err", int'(err0), 0);

    // Small FIFO: fill, full push+pop, then overflow.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 1, 1'($urandom), 0, 0);
      cyc();
    end
    chk("fill_ovf", int'(ovf1), 0);
    drive(0, 0, 1, 1, 1, 0);
    cyc();
    chk("fullpp_ovf", int'(ovf1), 0);
    drive(0, 0, 1, 0, 0, 0);
    cyc();
    chk("drop_ovf", int'(ovf1), 1);
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 1, 0);
      cyc();
    end
    chk("drain_unf", int'(unf1), 0);
    drive(0, 0, 0, 0, 1, 0);
    cyc();
    chk("empty_unf", int'(unf1), 1);

    // Saturation on the 4-bit counts.
    for (int k = 0; k < 200; k++) fl[k] = 1;
    do_reset();
    stream(20, 2, 20, -1, 0, fl);
    chk("sat_done", dcnt[1], 1);
    chk("sat_err", int'(err1), 15);
    chk("sat_bit", int'(bit1), 15);
    chk("sat_err_big", int'(err0), 20);

    // Reset inside a window.
    do_reset();
    drive(1, 50, 1, 1, 0, 0);
    cyc();
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 1, 1, 1, 1);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("mr_busy", int'(busy0), 0);
    chk("mr_err", int'(err0), 0);
    chk("mr_bit", int'(bit0), 0);
    drive(0, 0, 0, 0, 1, 0);
    cyc();
    chk("mr_unf", int'(unf0), 1);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc();
    chk("mr_nodone", dcnt[0], 0);

    // Random traffic against the model.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 40),
            $urandom_range(0, 9) < 6,
            1'($urandom),
            $urandom_range(0, 9) < 5,
            1'($urandom));
      cyc();
    end
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
